// File: rtl/test_sequencer.sv
// Runs NTESTS test engines one after another (init pulse, wait for progress, collect result).
// Optional macro TESTSEQ_CONTINUOUS_EN: loop_en restarts the sequence from DONE with sticky failures.
module test_sequencer #(
    parameter int NTESTS      = 4,
    parameter int TIMEOUT_W   = 24,
    parameter int INIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              loop_en,
    output logic [NTESTS-1:0] test_init,
    input  logic [NTESTS-1:0] test_progress,
    input  logic [NTESTS-1:0] test_result,
    output logic              busy,
    output logic              done,
    output logic [NTESTS-1:0] pass_mask,
    output logic [NTESTS-1:0] fail_mask,
    output logic [NTESTS-1:0] timeout_mask,
    output logic [3:0]        cur_idx,
    output logic [15:0]       pass_count,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAITSTART, WAITEND, NEXT, DONE
    } state_t;

    // Last counter value before the phase budget of 2^TIMEOUT_W-1 cycles is exhausted.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [7:0]           INIT_LAST = 8'(INIT_CYCLES - 1);
    localparam logic [3:0]           IDX_LAST  = 4'(NTESTS - 1);

    state_t               state, state_n;
    logic [7:0]           init_cnt, init_cnt_n;
    logic [TIMEOUT_W-1:0] tmo_cnt, tmo_cnt_n;
    logic [3:0]           idx_n;
    logic [NTESTS-1:0]    pass_n, fail_n, tmo_n;
    logic [15:0]          count_n;
    logic [NTESTS-1:0]    cur_bit;
    logic                 prog_cur, res_cur, loop_go;

    assign cur_bit  = NTESTS'(1) << cur_idx;
    assign prog_cur = |(test_progress & cur_bit);
    assign res_cur  = |(test_result & cur_bit);

`ifdef TESTSEQ_CONTINUOUS_EN
    assign loop_go = loop_en;
`else
    logic unused_loop_en;
    assign unused_loop_en = loop_en;
    assign loop_go        = 1'b0;
`endif

    assign test_init = (state == LAUNCH) ? cur_bit : '0;
    assign busy      = (state == LAUNCH) || (state == WAITSTART) ||
                       (state == WAITEND) || (state == NEXT);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_comb begin
        state_n    = state;
        init_cnt_n = init_cnt;
        tmo_cnt_n  = tmo_cnt;
        idx_n      = cur_idx;
        pass_n     = pass_mask;
        fail_n     = fail_mask;
        tmo_n      = timeout_mask;
        count_n    = pass_count;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    pass_n     = '0;
                    fail_n     = '0;
                    tmo_n      = '0;
                    idx_n      = 4'd0;
                    init_cnt_n = 8'd0;
                    state_n    = LAUNCH;
                end else if (state == DONE && loop_go) begin
                    // Continuous loop keeps failures and timeouts sticky across passes.
                    pass_n     = '0;
                    idx_n      = 4'd0;
                    init_cnt_n = 8'd0;
                    state_n    = LAUNCH;
                end
            end
            LAUNCH: begin
                if (init_cnt == INIT_LAST) begin
                    tmo_cnt_n = '0;
                    state_n   = WAITSTART;
                end else begin
                    init_cnt_n = init_cnt + 8'd1;
                end
            end
            WAITSTART: begin
                if (prog_cur) begin
                    tmo_cnt_n = '0;
                    state_n   = WAITEND;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_n   = timeout_mask | cur_bit;
                    fail_n  = fail_mask | cur_bit;
                    state_n = NEXT;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            WAITEND: begin
                // A falling progress flag wins over a timeout on the same cycle.
                if (!prog_cur) begin
                    if (res_cur) pass_n = pass_mask | cur_bit;
                    else         fail_n = fail_mask | cur_bit;
                    state_n = NEXT;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_n   = timeout_mask | cur_bit;
                    fail_n  = fail_mask | cur_bit;
                    state_n = NEXT;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            NEXT: begin
                if (cur_idx == IDX_LAST) begin
                    if (fail_mask == '0 && pass_count != 16'hFFFF)
                        count_n = pass_count + 16'd1;
                    state_n = DONE;
                end else begin
                    idx_n      = cur_idx + 4'd1;
                    init_cnt_n = 8'd0;
                    state_n    = LAUNCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            init_cnt     <= 8'd0;
            tmo_cnt      <= '0;
            cur_idx      <= 4'd0;
            pass_mask    <= '0;
            fail_mask    <= '0;
            timeout_mask <= '0;
            pass_count   <= 16'd0;
        end else begin
            state        <= state_n;
            init_cnt     <= init_cnt_n;
            tmo_cnt      <= tmo_cnt_n;
            cur_idx      <= idx_n;
            pass_mask    <= pass_n;
            fail_mask    <= fail_n;
            timeout_mask <= tmo_n;
            pass_count   <= count_n;
        end
    end

endmodule
